alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter: DATA_W, 32, operand/result width (the ALU is 32-bit; no other value is supported).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has an operation.
- reqN_ready  out  1  the arbiter accepts requester N's operation this cycle.
- reqN_op  in  5  ALU opcode.
- reqN_a, reqN_b  in  DATA_W  operands.
- reqN_srcA  in  1  shift amount taken from a[10:6].
- rspN_valid  out  1  requester N's result is held.
- rspN_ready  in  1  requester N consumes its result.
- rspN_res  out  DATA_W  result.
- rspN_ov  out  1  captured overflow bit.
- alu_op  out  5  drives the shared ALU.
- alu_a, alu_b  out  DATA_W  drive the shared ALU.
- alu_srcA  out  1  drives the shared ALU.
- alu_res  in  DATA_W  combinational ALU result.
- alu_int_ov  in  1  combinational ALU overflow.

Function
REQ-003 A request SHALL be accepted at a rising edge where reqN_valid and reqN_ready are both 1.
REQ-004 Each requester SHALL have at most one outstanding operation, meaning accepted but its response not yet consumed.
REQ-005 Requester N SHALL be eligible when reqN_valid=1 and it has nothing outstanding, or its outstanding response is being consumed this cycle (rspN_valid & rspN_ready).
REQ-006 The arbiter SHALL assert at most one reqN_ready per cycle, and only for an eligible requester; reqN_ready SHALL NOT depend on reqN_valid of the same requester.
REQ-007 Arbitration SHALL be round-robin: if both requesters are eligible, the one not granted last wins; if only one is eligible, it wins.
REQ-008 The last-grant pointer SHALL update only on an accepted request.
REQ-009 On acceptance, the op, a, b and srcA fields and the owner ID SHALL be registered into the issue stage at that edge; the alu_* outputs SHALL come directly from these registers.
REQ-010 In any cycle with no acceptance, the issue registers SHALL load all-zero (op 5'b00000) and issue_valid SHALL be 0.
REQ-011 At the edge after acceptance, alu_res and alu_int_ov SHALL be captured into the owner's response buffer, and rspN_valid SHALL be set.
REQ-012 The latency from acceptance edge to rspN_valid rising SHALL be exactly 1 cycle.
REQ-013 The issue stage SHALL never stall; the owner's buffer is guaranteed free by REQ-005.
REQ-014 rspN_valid, rspN_res and rspN_ov SHALL hold unchanged until rspN_ready=1 while rspN_valid=1; rspN_valid SHALL clear at that edge unless a new result for N is captured at the same edge, in which case the new result replaces the old one and valid stays 1.
REQ-015 Aggregate throughput SHALL be one operation per cycle; with both requesters streaming and always ready, grants SHALL alternate 0,1,0,1.
REQ-016 Results SHALL pass through unmodified: no width change, and ov is taken as-is from alu_int_ov.

Reset
REQ-017 While reset=1 at a rising edge: issue_valid, rsp0_valid and rsp1_valid SHALL clear; all issue registers, rspN_res and rspN_ov SHALL become 0; the last-grant pointer SHALL be set to 1, so requester 0 wins the first tie.
REQ-018 While reset=1, reqN_ready SHALL be 0.
REQ-019 Reset mid-operation SHALL discard any in-flight or held result, and no response for it SHALL ever appear.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single add: req0 op=00001, a=5, b=7, accepted at edge k -> rsp0_valid=1 after edge k+1, rsp0_res=12, rsp0_ov=0.
- Tie: both requesters valid from reset release -> req0 granted first, then req1; rsp0 result from req0's operands, rsp1 result from req1's operands; grants continue alternating.
- Backpressure: rsp1_ready=0 with rsp1 holding 3 -> req1_ready=0, req0 continues to be served, rsp1_res stays 3; raise rsp1_ready -> req1 accepted in the same cycle as consumption.
- Back-to-back same requester: req0 sub 10-4, then slt (op 01010) a=-1 b=1 with rsp0_ready=1 -> results 6 then 1 on consecutive response cycles.
- Overflow passthrough: ALU model drives alu_int_ov=1 for the captured op -> rspN_ov=1.
- Reset mid-op: assert reset the edge after acceptance -> rsp0_valid stays 0, alu_op=00000, and req0 wins the first grant after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_srcA,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_srcA,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_res,
  output logic              rsp0_ov,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_res,
  output logic              rsp1_ov,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_srcA,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_int_ov
);
  logic issue_valid, issue_owner, last;
  logic free0, free1, elig0, elig1, acc0, acc1, cap0, cap1;
  // a requester is free when nothing of its own is in the issue stage and its buffer is empty or draining
  assign cap0 = issue_valid & !issue_owner;
  assign cap1 = issue_valid & issue_owner;
  assign free0 = !cap0 & (!rsp0_valid | rsp0_ready);
  assign free1 = !cap1 & (!rsp1_valid | rsp1_ready);
  assign elig0 = req0_valid & free0;
  assign elig1 = req1_valid & free1;
  assign req0_ready = !reset & free0 & (last | !elig1);
  assign req1_ready = !reset & free1 & (!last | !elig0);
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_owner <= 1'b0;
      last        <= 1'b1;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_srcA    <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_res    <= '0;
      rsp0_ov     <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_res    <= '0;
      rsp1_ov     <= 1'b0;
    end else begin
      issue_valid <= acc0 | acc1;
      issue_owner <= acc1;
      if (acc0 | acc1) last <= acc1;
      alu_op      <= acc0 ? req0_op   : acc1 ? req1_op   : '0;
      alu_a       <= acc0 ? req0_a    : acc1 ? req1_a    : '0;
      alu_b       <= acc0 ? req0_b    : acc1 ? req1_b    : '0;
      alu_srcA    <= acc0 ? req0_srcA : acc1 ? req1_srcA : 1'b0;
      rsp0_valid  <= cap0 | (rsp0_valid & !rsp0_ready);
      rsp1_valid  <= cap1 | (rsp1_valid & !rsp1_ready);
      if (cap0) begin
        rsp0_res <= alu_res;
        rsp0_ov  <= alu_int_ov;
      end
      if (cap1) begin
        rsp1_res <= alu_res;
        rsp1_ov  <= alu_int_ov;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenario bench for alu_arbiter with a small behavioural ALU
module tb_alu_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req0_ready, req0_srcA = 0;
  logic req1_valid = 0, req1_ready, req1_srcA = 0;
  logic [4:0] req0_op = 0, req1_op = 0, alu_op;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp0_valid, rsp0_ready = 1, rsp0_ov, rsp1_valid, rsp1_ready = 1, rsp1_ov;
  logic [31:0] rsp0_res, rsp1_res, alu_a, alu_b, alu_res, sum;
  logic alu_srcA, alu_int_ov;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_srcA(req0_srcA),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_srcA(req1_srcA),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_ov(rsp0_ov),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_ov(rsp1_ov),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_srcA(alu_srcA),
    .alu_res(alu_res), .alu_int_ov(alu_int_ov)
  );

  // behavioural ALU: 1 add, 2 sub, 10 slt; ov = signed add overflow
  always_comb begin
    sum = alu_a + alu_b;
    alu_res = alu_op == 5'd1 ? sum : alu_op == 5'd2 ? alu_a - alu_b :
              alu_op == 5'd10 ? {31'b0, $signed(alu_a) < $signed(alu_b)} : 32'd0;
    alu_int_ov = alu_op == 5'd1 && alu_a[31] == alu_b[31] && sum[31] != alu_a[31];
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1; req0_valid = 1; req1_valid = 1; req0_op = 5'd1; req1_op = 5'd1;
    step(2);
    compared++; if (req0_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    compared++; if (req1_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
    compared++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
    compared++; if (alu_op !== 5'd0 || alu_a !== 32'd0 || rsp0_res !== 32'd0) begin mismatched++; $display("FAIL reset_regs: op %0h a %0h res %0h expected 0", alu_op, alu_a, rsp0_res); end
    req0_valid = 0; req1_valid = 0; reset = 0;
    step();
  endtask

  task automatic test_single_add;
    req0_valid = 1; req0_op = 5'd1; req0_a = 5; req0_b = 7; rsp0_ready = 0;
    #1;
    compared++; if (req0_ready !== 1'b1) begin mismatched++; $display("FAIL add_ready: got %b expected 1", req0_ready); end
    step();
    req0_valid = 0;
    compared++; if (alu_op !== 5'd1 || alu_a !== 32'd5 || alu_b !== 32'd7) begin mismatched++; $display("FAIL add_issue: op %0h a %0h b %0h expected 1 5 7", alu_op, alu_a, alu_b); end
    compared++; if (rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL add_early: got %b expected 0", rsp0_valid); end
    step();
    compared++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd12 || rsp0_ov !== 1'b0) begin mismatched++; $display("FAIL add_rsp: valid %b res %0d ov %b expected 1 12 0", rsp0_valid, rsp0_res, rsp0_ov); end
    compared++; if (alu_op !== 5'd0) begin mismatched++; $display("FAIL add_idle_op: got %0h expected 0", alu_op); end
    step();
    compared++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd12) begin mismatched++; $display("FAIL add_hold: valid %b res %0d expected 1 12", rsp0_valid, rsp0_res); end
    rsp0_ready = 1;
    step();
    compared++; if (rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL add_consume: got %b expected 0", rsp0_valid); end
  endtask

  task automatic test_tie;
    reset = 1; step(); reset = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = 5'd1; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_op = 5'd1; req1_a = 10; req1_b = 20;
    #1;
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("FAIL tie_first: got %b expected 10", {req0_ready, req1_ready}); end
    step();
    compared++; if ({req0_ready, req1_ready} !== 2'b01 || alu_a !== 32'd1) begin mismatched++; $display("FAIL tie_second: ready %b a %0d expected 01 1", {req0_ready, req1_ready}, alu_a); end
    step();
    compared++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd3 || alu_a !== 32'd10) begin mismatched++; $display("FAIL tie_rsp0: valid %b res %0d a %0d expected 1 3 10", rsp0_valid, rsp0_res, alu_a); end
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("FAIL tie_third: got %b expected 10", {req0_ready, req1_ready}); end
    step();
    compared++; if (rsp1_valid !== 1'b1 || rsp1_res !== 32'd30) begin mismatched++; $display("FAIL tie_rsp1: valid %b res %0d expected 1 30", rsp1_valid, rsp1_res); end
    compared++; if ({req0_ready, req1_ready} !== 2'b01) begin mismatched++; $display("FAIL tie_fourth: got %b expected 01", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    step(3);
  endtask

  task automatic test_backpressure;
    rsp1_ready = 0; rsp0_ready = 1;
    req1_valid = 1; req1_op = 5'd1; req1_a = 1; req1_b = 2;
    #1;
    compared++; if (req1_ready !== 1'b1) begin mismatched++; $display("FAIL bp_accept1: got %b expected 1", req1_ready); end
    step();
    req1_a = 5; req1_b = 5;
    req0_valid = 1; req0_op = 5'd1; req0_a = 100; req0_b = 1;
    #1;
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("FAIL bp_serve0: got %b expected 10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0;
    compared++; if (rsp1_valid !== 1'b1 || rsp1_res !== 32'd3 || req1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold: valid %b res %0d ready %b expected 1 3 0", rsp1_valid, rsp1_res, req1_ready); end
    step();
    compared++; if (rsp0_res !== 32'd101 || rsp1_res !== 32'd3 || req1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_other: rsp0 %0d rsp1 %0d ready %b expected 101 3 0", rsp0_res, rsp1_res, req1_ready); end
    rsp1_ready = 1;
    #1;
    compared++; if (req1_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release: got %b expected 1", req1_ready); end
    step();
    req1_valid = 0;
    compared++; if (rsp1_valid !== 1'b0 || alu_a !== 32'd5) begin mismatched++; $display("FAIL bp_reissue: valid %b a %0d expected 0 5", rsp1_valid, alu_a); end
    step();
    compared++; if (rsp1_valid !== 1'b1 || rsp1_res !== 32'd10) begin mismatched++; $display("FAIL bp_newres: valid %b res %0d expected 1 10", rsp1_valid, rsp1_res); end
    step(2);
  endtask

  task automatic test_back_to_back;
    rsp0_ready = 1;
    req0_valid = 1; req0_op = 5'd2; req0_a = 10; req0_b = 4;
    step();
    req0_op = 5'd10; req0_a = 32'hFFFF_FFFF; req0_b = 1;
    #1;
    compared++; if (req0_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_busy: got %b expected 0", req0_ready); end
    step();
    compared++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd6 || req0_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_sub: valid %b res %0d ready %b expected 1 6 1", rsp0_valid, rsp0_res, req0_ready); end
    step();
    req0_valid = 0;
    step();
    compared++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd1) begin mismatched++; $display("FAIL b2b_slt: valid %b res %0d expected 1 1", rsp0_valid, rsp0_res); end
    step(2);
  endtask

  task automatic test_overflow;
    rsp1_ready = 1;
    req1_valid = 1; req1_op = 5'd1; req1_a = 32'h7FFF_FFFF; req1_b = 1;
    step();
    req1_valid = 0;
    step();
    compared++; if (rsp1_valid !== 1'b1 || rsp1_ov !== 1'b1 || rsp1_res !== 32'h8000_0000) begin mismatched++; $display("FAIL ov: valid %b ov %b res %0h expected 1 1 80000000", rsp1_valid, rsp1_ov, rsp1_res); end
    step(2);
  endtask

  task automatic test_reset_mid;
    rsp0_ready = 0;
    req1_valid = 1; req1_op = 5'd1; req1_a = 3; req1_b = 4;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_op = 5'd1; req0_a = 8; req0_b = 9;
    step();
    req0_valid = 0; reset = 1;
    step();
    compared++; if (rsp0_valid !== 1'b0 || alu_op !== 5'd0) begin mismatched++; $display("FAIL rmid_flush: valid %b op %0h expected 0 0", rsp0_valid, alu_op); end
    reset = 0;
    step(2);
    compared++; if (rsp0_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_ghost: got %b expected 0", rsp0_valid); end
    req0_valid = 1; req1_valid = 1;
    #1;
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("FAIL rmid_grant: got %b expected 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    chk("final_srcA_idle", {31'b0, alu_srcA}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
